// File: rtl/cacheline_burst_adaptor_if.sv
// Line-side and burst-side signal bundle for cacheline_burst_adaptor.
// master = cache core + memory side, slave = the adaptor.
interface cacheline_burst_adaptor_if #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
);
    logic                line_read;
    logic                line_write;
    logic [31:0]         line_address;
    logic [s_line-1:0]   line_wdata;
    logic [s_line-1:0]   line_rdata;
    logic                line_resp;
    logic                burst_read;
    logic                burst_write;
    logic [31:0]         burst_address;
    logic [s_burst-1:0]  burst_wdata;
    logic [s_burst-1:0]  burst_rdata;
    logic                burst_resp;

    modport master (
        output line_read, line_write, line_address, line_wdata,
        input  line_rdata, line_resp,
        input  burst_read, burst_write, burst_address, burst_wdata,
        output burst_rdata, burst_resp
    );

    modport slave (
        input  line_read, line_write, line_address, line_wdata,
        output line_rdata, line_resp,
        output burst_read, burst_write, burst_address, burst_wdata,
        input  burst_rdata, burst_resp
    );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Turns whole-line cache requests into num_beats-beat memory bursts.
// Optional BURST_ADDR_ALIGN_EN: line-align the outgoing burst address.
module cacheline_burst_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cacheline_burst_adaptor_if.slave bus
);
    localparam int num_beats = s_line / s_burst;
    localparam int cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [cnt_w-1:0]  cnt;
    logic [31:0]       addr_q;
    logic [s_line-1:0] wdata_q;
    logic [s_line-1:0] rdata_q;
    logic              in_burst;
    logic              last_strobe;

    assign in_burst    = (state == READ) || (state == WRITE);
    assign last_strobe = bus.burst_resp && (cnt == last_beat);

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: write wins over read; a burst ends on its last strobe.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.line_write) begin
                    state_nx = WRITE;
                end else if (bus.line_read) begin
                    state_nx = READ;
                end
            end
            READ, WRITE: begin
                if (last_strobe) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Beat counter advances only on strobes; parked at zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (in_burst && bus.burst_resp) begin
            cnt <= (cnt == last_beat) ? '0 : cnt + cnt_w'(1);
        end
    end

    // Capture address and writeback data when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE) begin
            if (bus.line_write) begin
                addr_q  <= bus.line_address;
                wdata_q <= bus.line_wdata;
            end else if (bus.line_read) begin
                addr_q  <= bus.line_address;
            end
        end
    end

    // Assemble fill data beat by beat, beat 0 in the low slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if ((state == READ) && bus.burst_resp) begin
            rdata_q[int'(cnt)*s_burst +: s_burst] <= bus.burst_rdata;
        end
    end

    assign bus.burst_read  = (state == READ);
    assign bus.burst_write = (state == WRITE);
    assign bus.line_resp   = (state == DONE);
    assign bus.line_rdata  = rdata_q;
    assign bus.burst_wdata = wdata_q[int'(cnt)*s_burst +: s_burst];

`ifdef BURST_ADDR_ALIGN_EN
    localparam int off_w = $clog2(s_line / 8);
    localparam logic [31:0] align_mask = ~((32'd1 << off_w) - 32'd1);
    assign bus.burst_address = addr_q & align_mask;
`else
    assign bus.burst_address = addr_q;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench for cacheline_burst_adaptor.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_cacheline_burst_adaptor;
    localparam int s_line  = 256;
    localparam int s_burst = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [s_line-1:0]  exp_line_q[$];
    logic [s_burst-1:0] exp_beat_q[$];
    logic [s_line-1:0]  last_fill = '0;

    cacheline_burst_adaptor_if #(.s_line(s_line), .s_burst(s_burst)) bus ();

    cacheline_burst_adaptor #(.s_line(s_line), .s_burst(s_burst)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef BURST_ADDR_ALIGN_EN
        return a & 32'hFFFF_FFE0;
`else
        return a;
`endif
    endfunction

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic idle_inputs();
        bus.line_read    = 1'b0;
        bus.line_write   = 1'b0;
        bus.line_address = '0;
        bus.line_wdata   = '0;
        bus.burst_rdata  = '0;
        bus.burst_resp   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.burst_read, bus.burst_write, bus.line_resp} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000",
                     {bus.burst_read, bus.burst_write, bus.line_resp});
        end
        total++;
        if (bus.line_rdata !== '0 || bus.burst_address !== 32'h0 ||
            bus.burst_wdata !== '0) begin
            bad++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0",
                     bus.line_rdata, bus.burst_address, bus.burst_wdata);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({bus.burst_read, bus.burst_write, bus.line_resp} !== 3'b000) begin
                bad++;
                $display("FAIL idle_quiet: cyc %0d got %b want 000", i,
                         {bus.burst_read, bus.burst_write, bus.line_resp});
            end
        end
    endtask

    task automatic test_fill();
        logic [63:0]  b[4];
        logic [255:0] got;
        b = '{rep(8'h11), rep(8'h22), rep(8'h33), rep(8'h44)};
        bus.line_read    = 1'b1;
        bus.line_address = 32'h0000_1D80;
        exp_line_q.push_back({b[3], b[2], b[1], b[0]});
        @(negedge clk);
        bus.line_read = 1'b0;
        total++;
        if (bus.burst_read !== 1'b1 || bus.burst_address !== exp_addr(32'h1D80)) begin
            bad++;
            $display("FAIL fill_start: rd=%b addr=%h want 1 %h",
                     bus.burst_read, bus.burst_address, exp_addr(32'h1D80));
        end
        for (int i = 0; i < 4; i++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = b[i];
            total++;
            if (bus.burst_read !== 1'b1 || bus.line_resp !== 1'b0) begin
                bad++;
                $display("FAIL fill_beat%0d: rd=%b resp=%b want 1 0",
                         i, bus.burst_read, bus.line_resp);
            end
            @(negedge clk);
        end
        bus.burst_resp = 1'b0;
        total++;
        if (bus.line_resp !== 1'b1 || bus.burst_read !== 1'b0) begin
            bad++;
            $display("FAIL fill_resp: resp=%b rd=%b want 1 0",
                     bus.line_resp, bus.burst_read);
        end
        got = bus.line_rdata;
        total++;
        if (exp_line_q.size() == 0) begin
            bad++;
            $display("FAIL fill_data: scoreboard empty, got %h", got);
        end else begin
            last_fill = exp_line_q.pop_front();
            if (got !== last_fill) begin
                bad++;
                $display("FAIL fill_data: got %h want %h", got, last_fill);
            end
        end
        @(negedge clk);
        total++;
        if (bus.line_resp !== 1'b0 || bus.line_rdata !== last_fill) begin
            bad++;
            $display("FAIL fill_after: resp=%b rdata=%h want 0 %h",
                     bus.line_resp, bus.line_rdata, last_fill);
        end
    endtask

    task automatic test_writeback();
        logic [63:0] d[4];
        bit          pat[7];
        d   = '{64'hD000_0000_0000_00D0, 64'hD111_1111_1111_11D1,
                64'hD222_2222_2222_22D2, 64'hD333_3333_3333_33D3};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.line_write   = 1'b1;
        bus.line_address = 32'h0000_2040;
        bus.line_wdata   = {d[3], d[2], d[1], d[0]};
        for (int i = 0; i < 4; i++) exp_beat_q.push_back(d[i]);
        @(negedge clk);
        bus.line_write = 1'b0;
        bus.line_wdata = '0;
        for (int k = 0; k < 7; k++) begin
            bus.burst_resp = pat[k];
            bus.line_read  = (k == 2);
            total++;
            if (bus.burst_write !== 1'b1 || bus.burst_read !== 1'b0 ||
                bus.line_resp !== 1'b0) begin
                bad++;
                $display("FAIL wb_ctrl%0d: wr=%b rd=%b resp=%b want 1 0 0",
                         k, bus.burst_write, bus.burst_read, bus.line_resp);
            end
            total++;
            if (exp_beat_q.size() == 0) begin
                bad++;
                $display("FAIL wb_beat%0d: scoreboard empty got %h",
                         k, bus.burst_wdata);
            end else if (bus.burst_wdata !== exp_beat_q[0]) begin
                bad++;
                $display("FAIL wb_beat%0d: got %h want %h",
                         k, bus.burst_wdata, exp_beat_q[0]);
            end
            if (pat[k] && exp_beat_q.size() > 0) void'(exp_beat_q.pop_front());
            @(negedge clk);
        end
        bus.burst_resp = 1'b0;
        bus.line_read  = 1'b0;
        total++;
        if (bus.line_resp !== 1'b1 || bus.burst_write !== 1'b0) begin
            bad++;
            $display("FAIL wb_resp: resp=%b wr=%b want 1 0",
                     bus.line_resp, bus.burst_write);
        end
        total++;
        if (bus.line_rdata !== last_fill || exp_beat_q.size() != 0) begin
            bad++;
            $display("FAIL wb_rdata: got %h want %h left=%0d want 0",
                     bus.line_rdata, last_fill, exp_beat_q.size());
        end
        @(negedge clk);
        total++;
        if (bus.line_resp !== 1'b0 || bus.burst_read !== 1'b0) begin
            bad++;
            $display("FAIL wb_after: resp=%b rd=%b want 0 0",
                     bus.line_resp, bus.burst_read);
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] d[4];
        d = '{rep(8'hA0), rep(8'hA1), rep(8'hA2), rep(8'hA3)};
        bus.line_read    = 1'b1;
        bus.line_write   = 1'b1;
        bus.line_address = 32'h0000_3000;
        bus.line_wdata   = {d[3], d[2], d[1], d[0]};
        for (int i = 0; i < 4; i++) exp_beat_q.push_back(d[i]);
        @(negedge clk);
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.burst_resp = 1'b1;
            total++;
            if (bus.burst_write !== 1'b1 || bus.burst_read !== 1'b0) begin
                bad++;
                $display("FAIL simul_ctrl%0d: wr=%b rd=%b want 1 0",
                         i, bus.burst_write, bus.burst_read);
            end
            total++;
            if (exp_beat_q.size() == 0) begin
                bad++;
                $display("FAIL simul_beat%0d: scoreboard empty", i);
            end else begin
                logic [63:0] e;
                e = exp_beat_q.pop_front();
                if (bus.burst_wdata !== e) begin
                    bad++;
                    $display("FAIL simul_beat%0d: got %h want %h",
                             i, bus.burst_wdata, e);
                end
            end
            @(negedge clk);
        end
        bus.burst_resp = 1'b0;
        total++;
        if (bus.line_resp !== 1'b1 || bus.line_rdata !== last_fill) begin
            bad++;
            $display("FAIL simul_resp: resp=%b rdata=%h want 1 %h",
                     bus.line_resp, bus.line_rdata, last_fill);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] b[8];
        for (int i = 0; i < 8; i++) b[i] = rep(8'(8'h50 + i));
        bus.line_read    = 1'b1;
        bus.line_address = 32'h0000_4000;
        exp_line_q.push_back({b[3], b[2], b[1], b[0]});
        exp_line_q.push_back({b[7], b[6], b[5], b[4]});
        for (int burst = 0; burst < 2; burst++) begin
            @(negedge clk);
            if (burst == 1) bus.line_read = 1'b0;
            total++;
            if (bus.burst_read !== 1'b1) begin
                bad++;
                $display("FAIL b2b_start%0d: rd=%b want 1", burst, bus.burst_read);
            end
            for (int i = 0; i < 4; i++) begin
                bus.burst_resp  = 1'b1;
                bus.burst_rdata = b[burst*4 + i];
                @(negedge clk);
            end
            bus.burst_resp = 1'b0;
            total++;
            if (bus.line_resp !== 1'b1) begin
                bad++;
                $display("FAIL b2b_resp%0d: resp=%b want 1", burst, bus.line_resp);
            end
            total++;
            if (exp_line_q.size() == 0) begin
                bad++;
                $display("FAIL b2b_data%0d: scoreboard empty", burst);
            end else begin
                last_fill = exp_line_q.pop_front();
                if (bus.line_rdata !== last_fill) begin
                    bad++;
                    $display("FAIL b2b_data%0d: got %h want %h",
                             burst, bus.line_rdata, last_fill);
                end
            end
            @(negedge clk);
            total++;
            if (bus.burst_read !== 1'b0 || bus.line_resp !== 1'b0) begin
                bad++;
                $display("FAIL b2b_idle%0d: rd=%b resp=%b want 0 0",
                         burst, bus.burst_read, bus.line_resp);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] b[4];
        bus.line_read    = 1'b1;
        bus.line_address = 32'h0000_5000;
        @(negedge clk);
        bus.line_read = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = rep(8'hEE);
            @(negedge clk);
        end
        bus.burst_resp = 1'b0;
        total++;
        if (bus.burst_read !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: rd=%b want 1", bus.burst_read);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.burst_read !== 1'b0 || bus.line_rdata !== '0) begin
            bad++;
            $display("FAIL rst_mid_async: rd=%b rdata=%h want 0 0",
                     bus.burst_read, bus.line_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b = '{rep(8'h61), rep(8'h62), rep(8'h63), rep(8'h64)};
        bus.line_read    = 1'b1;
        bus.line_address = 32'h0000_5100;
        exp_line_q.push_back({b[3], b[2], b[1], b[0]});
        @(negedge clk);
        bus.line_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = b[i];
            @(negedge clk);
        end
        bus.burst_resp = 1'b0;
        total++;
        if (bus.line_resp !== 1'b1 || exp_line_q.size() == 0) begin
            bad++;
            $display("FAIL rst_mid_resp: resp=%b want 1 queue=%0d",
                     bus.line_resp, exp_line_q.size());
        end else begin
            last_fill = exp_line_q.pop_front();
            if (bus.line_rdata !== last_fill) begin
                bad++;
                $display("FAIL rst_mid_data: got %h want %h",
                         bus.line_rdata, last_fill);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_align();
        bus.line_read    = 1'b1;
        bus.line_address = 32'h0000_1D9C;
        @(negedge clk);
        bus.line_read    = 1'b0;
        bus.line_address = 32'hFFFF_FFFF;
        total++;
        if (bus.burst_address !== exp_addr(32'h0000_1D9C)) begin
            bad++;
            $display("FAIL align_addr: got %h want %h",
                     bus.burst_address, exp_addr(32'h0000_1D9C));
        end
        for (int i = 0; i < 4; i++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = rep(8'(8'h70 + i));
            @(negedge clk);
        end
        bus.burst_resp = 1'b0;
        total++;
        if (bus.line_resp !== 1'b1) begin
            bad++;
            $display("FAIL align_resp: resp=%b want 1", bus.line_resp);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.burst_address !== exp_addr(32'h0000_1D9C)) begin
            bad++;
            $display("FAIL align_hold: got %h want %h",
                     bus.burst_address, exp_addr(32'h0000_1D9C));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_writeback();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_burst();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
